// File: rtl/cram_axi_rd_slave.sv
// AXI4 read-only slave for the code RAM: one burst at a time, 1-cycle synchronous memory,
// output register plus 1-entry skid buffer. Optional macro CRAM_ERR_RESP_EN adds SLVERR on out-of-range beats.
module cram_axi_rd_slave #(
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               s_cram_arid,
    input  logic [31:0]              s_cram_araddr,
    input  logic [7:0]               s_cram_arlen,
    input  logic [2:0]               s_cram_arsize,
    input  logic [1:0]               s_cram_arburst,
    input  logic                     s_cram_arlock,
    input  logic [3:0]               s_cram_arcache,
    input  logic [2:0]               s_cram_arprot,
    input  logic [3:0]               s_cram_arqos,
    input  logic                     s_cram_arvalid,
    output logic                     s_cram_arready,
    input  logic                     s_cram_rready,
    output logic [3:0]               s_cram_rid,
    output logic [31:0]              s_cram_rdata,
    output logic [1:0]               s_cram_rresp,
    output logic                     s_cram_rlast,
    output logic                     s_cram_rvalid,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t      state_q;
    logic        arready_q;
    logic [3:0]  rid_q;
    logic [29:0] addr_q, addr_d;
    logic [7:0]  len_q, cnt_q;
    logic [1:0]  burst_q;

    logic        mem_v_q, mem_last_q, mem_err_q;
    logic [31:0] mem_rdata_q;
    logic        skid_v_q, skid_last_q, skid_err_q;
    logic [31:0] skid_data_q;

    logic [31:0] mem [DEPTH];

    logic        consume, rd_en, mem_keep, last_issue, wrap_ok, rd_err, err_out;
    logic [29:0] wrap_mask;
    logic        unused_ok;

    assign unused_ok = ^{s_cram_araddr[1:0], s_cram_arsize, s_cram_arlock,
                         s_cram_arcache, s_cram_arprot, s_cram_arqos};

    // The visible beat is the skid entry when present, otherwise the memory output register.
    assign s_cram_rvalid  = skid_v_q | mem_v_q;
    assign s_cram_arready = arready_q;
    assign s_cram_rid     = rid_q;
    assign s_cram_rlast   = skid_v_q ? skid_last_q : (mem_v_q & mem_last_q);
    assign err_out        = skid_v_q ? skid_err_q  : (mem_v_q & mem_err_q);
    assign s_cram_rresp   = err_out ? 2'b10 : 2'b00;

    assign consume    = s_cram_rvalid & s_cram_rready;
    // A read may issue unless both slots are full and nothing leaves this cycle.
    assign rd_en      = (state_q == BURST) && !(skid_v_q && mem_v_q && !consume);
    // The memory register still holds an undelivered beat after this edge.
    assign mem_keep   = mem_v_q && !(consume && !skid_v_q);
    assign last_issue = (cnt_q == len_q);
    assign wrap_ok    = (burst_q == 2'b10) &&
                        (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
    assign wrap_mask  = {22'b0, len_q};

`ifdef CRAM_ERR_RESP_EN
    assign rd_err = ({2'b00, addr_q} >= 32'(DEPTH));
`else
    assign rd_err = 1'b0;
`endif

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        s_cram_rdata = 32'h0;
        if (skid_v_q)
            s_cram_rdata = skid_data_q;
        else if (mem_v_q && !mem_err_q)
            s_cram_rdata = mem_rdata_q;
    end

    always_comb begin
        addr_d = addr_q + 30'd1;
        if (burst_q == 2'b00)
            addr_d = addr_q;
        else if (wrap_ok)
            addr_d = (addr_q & ~wrap_mask) | ((addr_q + 30'd1) & wrap_mask);
    end

    // NOTE: the memory array and its read register carry no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (rd_en)
            mem_rdata_q <= mem[addr_q[AW-1:0]];
        if (ld_we)
            mem[ld_addr] <= ld_data;
    end

    // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            rid_q       <= 4'h0;
            addr_q      <= 30'h0;
            len_q       <= 8'h0;
            cnt_q       <= 8'h0;
            burst_q     <= 2'b01;
            mem_v_q     <= 1'b0;
            mem_last_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
            skid_err_q  <= 1'b0;
            skid_data_q <= 32'h0;
        end else begin
            if (rd_en) begin
                if (mem_keep) begin
                    skid_v_q    <= 1'b1;
                    skid_data_q <= mem_err_q ? 32'h0 : mem_rdata_q;
                    skid_last_q <= mem_last_q;
                    skid_err_q  <= mem_err_q;
                end else begin
                    skid_v_q <= skid_v_q && !consume;
                end
                mem_v_q    <= 1'b1;
                mem_last_q <= last_issue;
                mem_err_q  <= rd_err;
                addr_q     <= addr_d;
                cnt_q      <= cnt_q + 8'd1;
            end else begin
                skid_v_q <= skid_v_q && !consume;
                mem_v_q  <= mem_keep;
            end

            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (s_cram_arvalid && arready_q) begin
                        state_q   <= BURST;
                        arready_q <= 1'b0;
                        rid_q     <= s_cram_arid;
                        addr_q    <= s_cram_araddr[31:2];
                        len_q     <= s_cram_arlen;
                        burst_q   <= s_cram_arburst;
                        cnt_q     <= 8'h0;
                    end
                end
                BURST: begin
                    if (rd_en && last_issue)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (consume && s_cram_rlast) begin
                        state_q   <= IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
